// File: rtl/wb_clint_multi_slave.sv
// Wishbone CLINT: shared prescaled 64-bit mtime, per-hart mtimecmp/msip, timer/sw IRQs.
// Define CLINT_MTIME_SNAPSHOT_EN for a coherent LO-then-HI mtime read via a hi-word shadow.
package wb_clint_pkg;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_master_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;
  } wb_slave_t;
endpackage

module wb_clint_multi_slave
  import wb_clint_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  wb_master_t           wb_m_i,
  output wb_slave_t            wb_s_o,
  output logic [NUM_HARTS-1:0] timer_irq_o,
  output logic [NUM_HARTS-1:0] sw_irq_o
);
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic [CW-1:0]        cnt_q;
  logic                 ack_q, err_q;
  logic [31:0]          dat_q;
  logic                 tick, accept, wr;
  logic [15:0]          off, cmp_off;
  logic                 sel_msip, sel_cmp, sel_mt_lo, sel_mt_hi, mapped, cmp_hi;
  logic [HW-1:0]        h_msip, h_cmp;
  logic [31:0]          rdata, mt_hi_rd;
  logic                 unused_adr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign unused_adr = ^wb_m_i.adr[31:16];
  assign off        = wb_m_i.adr[15:0];
  assign cmp_off    = off - 16'h4000;
  assign sel_msip   = (off[1:0] == 2'b00) && (32'(off) < 4 * NUM_HARTS);
  assign sel_cmp    = (off[1:0] == 2'b00) && (off >= 16'h4000) && (32'(cmp_off) < 8 * NUM_HARTS);
  assign sel_mt_lo  = (off == 16'hBFF8);
  assign sel_mt_hi  = (off == 16'hBFFC);
  assign mapped     = sel_msip | sel_cmp | sel_mt_lo | sel_mt_hi;
  assign h_msip     = off[HW+1:2];
  assign h_cmp      = cmp_off[HW+2:3];
  assign cmp_hi     = off[2];

  assign accept = wb_m_i.cyc & wb_m_i.stb & ~ack_q & ~err_q;
  assign wr     = accept & wb_m_i.we;
  assign tick   = (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    rdata = '0;
    if (sel_msip)       rdata = {31'b0, msip_q[h_msip]};
    else if (sel_cmp)   rdata = cmp_hi ? mtimecmp_q[h_cmp][63:32] : mtimecmp_q[h_cmp][31:0];
    else if (sel_mt_lo) rdata = mtime_q[31:0];
    else if (sel_mt_hi) rdata = mt_hi_rd;
  end

  // A half-word write overrides the tick for that half and blocks the carry across halves.
  always_comb begin
    mtime_d = mtime_q + {63'b0, tick};
    if (wr && sel_mt_lo)
      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wb_m_i.dat, wb_m_i.sel)};
    else if (wr && sel_mt_hi)
      mtime_d = {merge(mtime_q[63:32], wb_m_i.dat, wb_m_i.sel), mtime_q[31:0] + {31'b0, tick}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q     <= '0;
      cnt_q       <= '0;
      msip_q      <= '0;
      timer_irq_o <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
    end else begin
      mtime_q <= mtime_d;
      cnt_q   <= tick ? '0 : cnt_q + CW'(1);
      ack_q   <= accept & mapped;
      err_q   <= accept & ~mapped;
      dat_q   <= accept ? rdata : '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && sel_msip && (h_msip == HW'(h)) && wb_m_i.sel[0]) msip_q[h] <= wb_m_i.dat[0];
        if (wr && sel_cmp && (h_cmp == HW'(h))) begin
          if (cmp_hi) mtimecmp_q[h][63:32] <= merge(mtimecmp_q[h][63:32], wb_m_i.dat, wb_m_i.sel);
          else        mtimecmp_q[h][31:0]  <= merge(mtimecmp_q[h][31:0], wb_m_i.dat, wb_m_i.sel);
        end
        timer_irq_o[h] <= (mtime_q >= mtimecmp_q[h]);
      end
    end
  end

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           shadow_q <= '0;
    else if (accept && sel_mt_lo && !wb_m_i.we) shadow_q <= mtime_q[63:32];
    else if (wr && sel_mt_hi)              shadow_q <= mtime_d[63:32];
  end

  assign mt_hi_rd = shadow_q;
`else
  assign mt_hi_rd = mtime_q[63:32];
`endif

  assign sw_irq_o = msip_q;
  assign wb_s_o   = '{dat: dat_q, ack: ack_q, err: err_q, rty: 1'b0, stall: 1'b0};
endmodule

// File: tb/tb_wb_clint_multi_slave.sv
// Bench for wb_clint_multi_slave (2 harts, prescale 4): directed + random accesses vs a spec-level model.
module tb_wb_clint_multi_slave;
  import wb_clint_pkg::*;
  localparam int NH = 2;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wb_master_t    m;
  wb_slave_t     s;
  logic [NH-1:0] tirq, sirq;
  int            ntests = 0;
  int            nfail  = 0;

  always #5 clk = ~clk;

  wb_clint_multi_slave #(.NUM_HARTS(NH), .PRESCALE(PS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_m_i(m), .wb_s_o(s),
    .timer_irq_o(tirq), .sw_irq_o(sirq)
  );

  // Reference model: state as plain variables, mtime ticks on every PS-th edge after reset.
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_tirq;
  logic [31:0]   m_shadow, m_rdat;
  logic          m_ack, m_err, m_pend;
  int            m_edges;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wdat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // 0 unmapped, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
  function automatic int kind_of(input logic [31:0] adr, output int h);
    int off;
    off = int'(adr[15:0]);
    h = 0;
    if (off % 4 != 0) return 0;
    if (off < 4 * NH) begin h = off / 4; return 1; end
    if (off >= 'h4000 && off < 'h4000 + 8 * NH) begin
      h = (off - 'h4000) / 8;
      return (off % 8 == 0) ? 2 : 3;
    end
    if (off == 'hBFF8) return 4;
    if (off == 'hBFFC) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int k, input int h);
    case (k)
      1: return {31'b0, m_msip[h]};
      2: return m_cmp[h][31:0];
      3: return m_cmp[h][63:32];
      4: return m_mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
      5: return m_shadow;
`else
      5: return m_mtime[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime = '0; m_msip = '0; m_tirq = '0; m_shadow = '0;
      m_pend = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_rdat = '0; m_edges = 0;
      for (int i = 0; i < NH; i++) m_cmp[i] = '1;
    end else begin
      bit tick, acc;
      int k, h;
      logic [63:0] nt;
      m_edges++;
      tick = (m_edges % PS == 0);
      for (int i = 0; i < NH; i++) m_tirq[i] = (m_mtime >= m_cmp[i]);
      acc    = m.cyc && m.stb && !m_pend;
      m_pend = acc;
      k      = kind_of(m.adr, h);
      nt     = m_mtime + 64'(tick);
      m_ack  = acc && (k != 0);
      m_err  = acc && (k == 0);
      m_rdat = acc ? m_read(k, h) : 32'h0;
      if (acc && m.we) begin
        case (k)
          1: if (m.sel[0]) m_msip[h] = m.dat[0];
          2: m_cmp[h][31:0]  = lanes(m_cmp[h][31:0], m.dat, m.sel);
          3: m_cmp[h][63:32] = lanes(m_cmp[h][63:32], m.dat, m.sel);
          4: nt = {m_mtime[63:32], lanes(m_mtime[31:0], m.dat, m.sel)};
          5: begin
            nt = {lanes(m_mtime[63:32], m.dat, m.sel), m_mtime[31:0] + 32'(tick)};
            m_shadow = nt[63:32];
          end
          default: ;
        endcase
      end else if (acc && k == 4) begin
        m_shadow = m_mtime[63:32];
      end
      m_mtime = nt;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input string tag);
    check({tag, ".tirq"}, 64'(tirq), 64'(m_tirq));
    check({tag, ".sirq"}, 64'(sirq), 64'(m_msip));
  endtask

  task automatic bus(input bit we, input logic [15:0] off, input logic [31:0] dat,
                     input logic [3:0] sel, input bit hold, input string tag,
                     output logic [31:0] rd, output logic ack, output logic err);
    @(negedge clk);
    m.cyc = 1'b1; m.stb = 1'b1; m.we = we;
    m.adr = 32'h3000_0000 | 32'(off); m.dat = dat; m.sel = sel;
    @(negedge clk);
    check({tag, ".ack"}, 64'(s.ack), 64'(m_ack));
    check({tag, ".err"}, 64'(s.err), 64'(m_err));
    if (m_ack || m_err) check({tag, ".dat"}, 64'(s.dat), 64'(m_rdat));
    check_irq(tag);
    rd = s.dat; ack = s.ack; err = s.err;
    if (hold) begin
      @(negedge clk);
      check({tag, ".hold_ack"}, 64'(s.ack), 64'(m_ack));
      check({tag, ".hold_err"}, 64'(s.err), 64'(m_err));
    end
    m.cyc = 1'b0; m.stb = 1'b0; m.we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        a, e;
    m = '0;
    repeat (2) @(negedge clk);
    check("rst.ack", 64'(s.ack), 64'h0);
    check("rst.err", 64'(s.err), 64'h0);
    check("rst.dat", 64'(s.dat), 64'h0);
    check("rst.tirq", 64'(tirq), 64'h0);
    check("rst.sirq", 64'(sirq), 64'h0);
    rst_n = 1'b1;

    bus(1'b0, 16'h4000, 32'h0, 4'hF, 1'b0, "cmp0_lo_rst", rd, a, e);
    check("cmp0_lo_rst.val", 64'(rd), 64'hFFFF_FFFF);
    check("cmp0_lo_rst.ack1", 64'(a), 64'h1);

    bus(1'b1, 16'hBFF8, 32'h0, 4'hF, 1'b0, "mt_lo_clr", rd, a, e);
    repeat (40) @(negedge clk);
    bus(1'b0, 16'hBFF8, 32'h0, 4'hF, 1'b0, "mt_40cyc", rd, a, e);
    check("mt_40cyc.range", 64'((rd == 32'd10) || (rd == 32'd11)), 64'h1);

    bus(1'b1, 16'h400C, 32'h0, 4'hF, 1'b0, "cmp1_hi", rd, a, e);
    bus(1'b1, 16'h4008, 32'h20, 4'hF, 1'b0, "cmp1_lo", rd, a, e);
    bus(1'b1, 16'hBFFC, 32'h0, 4'hF, 1'b0, "mt_hi0", rd, a, e);
    bus(1'b1, 16'hBFF8, 32'h1E, 4'hF, 1'b1, "mt_lo1e", rd, a, e);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_irq("tmr_rise");
    end
    check("tmr_rise.2b10", 64'(tirq), 64'h2);
    bus(1'b1, 16'h400C, 32'h1, 4'hF, 1'b0, "cmp1_raise", rd, a, e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_irq("tmr_fall");
    end
    check("tmr_fall.0", 64'(tirq), 64'h0);

    bus(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'b1110, 1'b0, "msip1_sel1110", rd, a, e);
    check("msip1_sel1110.irq", 64'(sirq[1]), 64'h0);
    bus(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'b0001, 1'b0, "msip1_sel0001", rd, a, e);
    @(negedge clk);
    check("msip1_sel0001.irq", 64'(sirq[1]), 64'h1);
    bus(1'b0, 16'h0004, 32'h0, 4'hF, 1'b0, "msip1_rd", rd, a, e);
    check("msip1_rd.val", 64'(rd), 64'h1);

    bus(1'b0, 16'h0008, 32'h0, 4'hF, 1'b0, "unm_0008", rd, a, e);
    check("unm_0008.err1", 64'(e), 64'h1);
    check("unm_0008.ack0", 64'(a), 64'h0);
    check("unm_0008.dat0", 64'(rd), 64'h0);
    bus(1'b1, 16'h0008, 32'hFFFF_FFFF, 4'hF, 1'b0, "unm_wr", rd, a, e);
    @(negedge clk);
    check("unm_wr.sirq", 64'(sirq), 64'h2);
    bus(1'b0, 16'h5000, 32'h0, 4'hF, 1'b1, "unm_5000", rd, a, e);
    check("unm_5000.err1", 64'(e), 64'h1);
    check("unm_5000.dat0", 64'(rd), 64'h0);

    // Place the LO write on a tick edge so the wrap lands between the LO and HI reads.
    bus(1'b1, 16'hBFFC, 32'h0, 4'hF, 1'b0, "snap_hi0", rd, a, e);
    while (m_edges % PS != 2) @(negedge clk);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, "snap_lo", rd, a, e);
    bus(1'b0, 16'hBFF8, 32'h0, 4'hF, 1'b0, "snap_rd_lo", rd, a, e);
    check("snap_rd_lo.val", 64'(rd), 64'hFFFF_FFFF);
    repeat (8) @(negedge clk);
    bus(1'b0, 16'hBFFC, 32'h0, 4'hF, 1'b0, "snap_rd_hi", rd, a, e);
`ifdef CLINT_MTIME_SNAPSHOT_EN
    check("snap_rd_hi.val", 64'(rd), 64'h0);
`else
    check("snap_rd_hi.val", 64'(rd), 64'h1);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [15:0] off;
      case ($urandom_range(0, 6))
        0:       off = 16'(4 * $urandom_range(0, NH));
        1, 2:    off = 16'('h4000 + 4 * $urandom_range(0, 2 * NH));
        3:       off = 16'hBFF8;
        4:       off = 16'hBFFC;
        5:       off = 16'($urandom_range(0, 16'hFFFF));
        default: off = 16'('h4000 + 4 * $urandom_range(0, 2 * NH - 1) + $urandom_range(1, 3));
      endcase
      bus(1'($urandom_range(0, 1)), off, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), "rnd", rd, a, e);
    end

    @(negedge clk);
    m.cyc = 1'b1; m.stb = 1'b1; m.we = 1'b0; m.adr = 32'h3000_4000; m.sel = 4'hF;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst.ack", 64'(s.ack), 64'h0);
    check("mid_rst.err", 64'(s.err), 64'h0);
    check("mid_rst.tirq", 64'(tirq), 64'h0);
    check("mid_rst.sirq", 64'(sirq), 64'h0);
    m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, 16'h4008, 32'h0, 4'hF, 1'b0, "post_rst_cmp1", rd, a, e);
    check("post_rst_cmp1.val", 64'(rd), 64'hFFFF_FFFF);
    bus(1'b0, 16'hBFF8, 32'h0, 4'hF, 1'b0, "post_rst_mt", rd, a, e);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
